// File: rtl/atetris_romdl_pkg.sv
// ROM download transmitter: shared FSM state type, address-space constants and bank meaning.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package atetris_romdl_pkg;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_STRB = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4
    } romdl_state_t;

    // ROMAD width and full image size (64K program + 64K character ROM)
    localparam int ATETRIS_ROM_AW      = 17;
    localparam int ATETRIS_IMAGE_BYTES = 131072;

    // Meaning of ROMAD[16]: which DLROM the byte lands in
    localparam logic ATETRIS_PRG_BANK = 1'b0;
    localparam logic ATETRIS_CHR_BANK = 1'b1;

    // Larger of two elaboration-time integers (used to size the timer)
    function automatic int romdl_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/atetris_romdl_timer.sv
// Loadable down-counter with a zero flag; times the strobe and gap phases.
// Latency: load takes effect next cycle; zero is combinational from the count.
// Backpressure: none; counts down freely and parks at zero.
module atetris_romdl_timer #(
    parameter int TW = 2
) (
    input  logic          ROMCL,
    input  logic          RESET_N,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] cnt_q;

    // Load on phase entry, otherwise count down to zero and hold there
    always_ff @(posedge ROMCL or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/atetris_romdl_tx.sv
// ROM download bus transmitter: byte stream in, sequential ROMAD/ROMDT with one ROMEN strobe per byte.
// Latency: ROMEN rises the cycle after accept, high STRB_CYC cycles, then GAP_CYC low cycles before next accept.
// Backpressure: IN_READY low during strobe/gap/idle and in a START cycle; optional checksum under ATETRIS_ROMDL_CKSUM_EN.
module atetris_romdl_tx
    import atetris_romdl_pkg::*;
#(
    parameter int AW          = ATETRIS_ROM_AW,
    parameter int IMAGE_BYTES = ATETRIS_IMAGE_BYTES,
    parameter int STRB_CYC    = 2,
    parameter int GAP_CYC     = 1
) (
    input  logic          ROMCL,
    input  logic          RESET_N,
    input  logic          START,
    input  logic          IN_VALID,
    input  logic [7:0]    IN_DATA,
    output logic          IN_READY,
    output logic [AW-1:0] ROMAD,
    output logic [7:0]    ROMDT,
    output logic          ROMEN,
    output logic          BUSY,
    output logic          DONE,
    output logic          OVF,
    output logic [15:0]   CKSUM
);

    // Timer wide enough to hold the longer of the two phase lengths minus one
    localparam int TW = romdl_max($clog2(romdl_max(STRB_CYC, GAP_CYC)), 1);
    localparam logic [TW-1:0] STRB_LD  = TW'(STRB_CYC - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);
    localparam logic [AW:0]   LAST_CNT = (AW + 1)'(IMAGE_BYTES);

    // Reject illegal configurations at elaboration
    if (STRB_CYC < 1) begin : g_bad_strb
        $error("atetris_romdl_tx: STRB_CYC must be >= 1");
    end
    if (GAP_CYC < 1) begin : g_bad_gap
        $error("atetris_romdl_tx: GAP_CYC must be >= 1");
    end
    if (IMAGE_BYTES < 1 || IMAGE_BYTES > (2 ** AW)) begin : g_bad_image
        $error("atetris_romdl_tx: IMAGE_BYTES must be in 1..2^AW");
    end

    romdl_state_t  state_q;
    logic          in_ready_q;
    logic [AW-1:0] romad_q;
    logic [7:0]    romdt_q;
    logic          romen_q;
    logic          busy_q;
    logic          done_q;
    logic          ovf_q;
    logic [AW:0]   count_q;
    logic          accept;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    // START wins over any handshake in the same cycle
    assign IN_READY = in_ready_q & ~START;
    assign accept   = IN_VALID & IN_READY;

    // Load the timer on entry to STRB (from an accept) and on entry to GAP
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = STRB_LD;
        if (state_q == ST_WAIT && accept) begin
            tmr_load = 1'b1;
            tmr_val  = STRB_LD;
        end else if (state_q == ST_STRB && tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
        end
    end

    atetris_romdl_timer #(
        .TW (TW)
    ) u_timer (
        .ROMCL    (ROMCL),
        .RESET_N  (RESET_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Transfer FSM with registered bus outputs, byte counter and sticky flags
    always_ff @(posedge ROMCL or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            romad_q    <= '0;
            romdt_q    <= '0;
            romen_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
        end else if (START) begin
            // Abort whatever is in flight, including a strobe, and restart at 0
            state_q    <= ST_WAIT;
            in_ready_q <= 1'b1;
            romad_q    <= '0;
            romen_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (accept) begin
                        state_q    <= ST_STRB;
                        in_ready_q <= 1'b0;
                        romdt_q    <= IN_DATA;
                        romen_q    <= 1'b1;
                        count_q    <= count_q + 1'b1;
                    end
                end
                ST_STRB: begin
                    if (tmr_zero) begin
                        state_q <= ST_GAP;
                        romen_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        in_ready_q <= 1'b1;
                        if (count_q == LAST_CNT) begin
                            // Last byte written: address holds, image complete
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            romad_q <= romad_q + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    // Surplus bytes are swallowed and flagged, never written
                    if (accept) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    romen_q    <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef ATETRIS_ROMDL_CKSUM_EN
    logic [15:0] cksum_q;

    // Running byte sum of written bytes, restarted by START
    always_ff @(posedge ROMCL or negedge RESET_N) begin
        if (!RESET_N) begin
            cksum_q <= '0;
        end else if (START) begin
            cksum_q <= '0;
        end else if (state_q == ST_WAIT && accept) begin
            cksum_q <= cksum_q + {8'h00, IN_DATA};
        end
    end

    assign CKSUM = cksum_q;
`else
    assign CKSUM = 16'h0000;
`endif

    assign ROMAD = romad_q;
    assign ROMDT = romdt_q;
    assign ROMEN = romen_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign OVF   = ovf_q;

endmodule
